// File: rtl/fe_power_seq.sv
// fe_power_seq: sequences front-end power, reset release and tuner I2C gate.
// Enables go power -> settle -> reset release -> hold -> I2C gate; disables
// apply on the next edge. CI/TPS overcurrent flags are filtered, latched and
// force the matching supply off.
//
// Ports:
//   clk               system clock
//   reset             synchronous, active-high
//   req_ctrl[7:0]     requested control byte, 1 = disabled / in reset
//                     (7 I2C gate, 6 CI power, 5 antenna 5V, 4 spare, 3:0 resets)
//   ci_overcurrent_n  async, active-low CI overcurrent flag
//   tps_overcurrent_n async, active-low TPS overcurrent flag
//   fault_clear       one-cycle pulse, clears latched faults whose input is high
//   out_ctrl[7:0]     applied control byte, same encoding as req_ctrl
//   busy              enable sequence in progress
//   oc_fault[1:0]     latched overcurrent: [0] CI, [1] TPS
module fe_power_seq #(
   parameter int unsigned PWR_SETTLE_CYC = 500000,
   parameter int unsigned RST_HOLD_CYC   = 50000,
   parameter int unsigned OC_FILTER_CYC  = 64,
   parameter int unsigned CNT_W          = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req_ctrl,
   input  logic       ci_overcurrent_n,
   input  logic       tps_overcurrent_n,
   input  logic       fault_clear,
   output logic [7:0] out_ctrl,
   output logic       busy,
   output logic [1:0] oc_fault
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PWR    = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_REL    = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;
   localparam logic [2:0] S_GATE   = 3'd5;

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(PWR_SETTLE_CYC);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RST_HOLD_CYC);
   localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(OC_FILTER_CYC - 1);
   localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(OC_FILTER_CYC);

   localparam logic [7:0] PWR_MASK  = 8'h60;
   localparam logic [7:0] RST_MASK  = 8'h0F;
   localparam logic [7:0] GATE_MASK = 8'h80;
   localparam logic [7:0] SEQ_MASK  = 8'hEF;

   logic [1:0]       sync0;
   logic [1:0]       sync1;
   logic [CNT_W-1:0] fcnt [2];

   logic [2:0]       state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [1:0]       pwr_q, pwr_n;
   logic [7:0]       out_n;
   logic             busy_n;

   logic [7:0]       blk_c;
   logic [7:0]       pend_c;
   logic [7:0]       base_c;
   logic [7:0]       clr_c;
   logic             abort_c;

   // Overcurrent synchronizers, low-time filters and fault latches ([0] CI, [1] TPS).
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0    <= 2'b11;
         sync1    <= 2'b11;
         fcnt[0]  <= '0;
         fcnt[1]  <= '0;
         oc_fault <= 2'b00;
      end else begin
         sync0 <= {tps_overcurrent_n, ci_overcurrent_n};
         sync1 <= sync0;
         for (int i = 0; i < 2; i++) begin
            if (sync1[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] != FILT_MAX) begin
               fcnt[i] <= fcnt[i] + CNT_W'(1);
            end
            // Latch needs the input low, clear needs it high, so latch has priority.
            if (!sync1[i] && (fcnt[i] == FILT_LAST)) begin
               oc_fault[i] <= 1'b1;
            end else if (fault_clear && sync1[i]) begin
               oc_fault[i] <= 1'b0;
            end
         end
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pwr_q    <= 2'b00;
         out_ctrl <= 8'hFF;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         pwr_q    <= pwr_n;
         out_ctrl <= out_n;
         busy     <= busy_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      blk_c   = {1'b0, oc_fault[0], oc_fault[1], 5'b00000};
      pend_c  = ~req_ctrl & out_ctrl & ~blk_c & SEQ_MASK;
      // Disables and fault forcing apply in every state; bit4 just follows.
      base_c    = out_ctrl | req_ctrl | blk_c;
      base_c[4] = req_ctrl[4];
      // A supply enabled by this sequence dropping again invalidates the wait.
      abort_c = ((req_ctrl[6] | oc_fault[0]) & pwr_q[1]) |
                ((req_ctrl[5] | oc_fault[1]) & pwr_q[0]);
      clr_c   = 8'h00;
      state_n = state_q;
      cnt_n   = cnt_q;
      pwr_n   = pwr_q;
      busy_n  = busy;
      out_n   = base_c;

      case (state_q)
         S_IDLE: begin
            if (|pend_c) begin
               state_n = S_PWR;
               busy_n  = 1'b1;
               pwr_n   = 2'b00;
            end
         end
         S_PWR: begin
            clr_c = pend_c & PWR_MASK;
            out_n = base_c & ~clr_c;
            pwr_n = {clr_c[6], clr_c[5]};
            if ((|clr_c) && (SETTLE_LD != '0)) begin
               cnt_n   = SETTLE_LD;
               state_n = S_SETTLE;
            end else begin
               state_n = S_REL;
            end
         end
         S_SETTLE: begin
            if (abort_c) begin
               state_n = S_IDLE;
               busy_n  = 1'b0;
               cnt_n   = '0;
            end else if (cnt_q <= CNT_W'(1)) begin
               state_n = S_REL;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         S_REL: begin
            clr_c = pend_c & RST_MASK;
            out_n = base_c & ~clr_c;
            if ((|clr_c) && (HOLD_LD != '0)) begin
               cnt_n   = HOLD_LD;
               state_n = S_HOLD;
            end else begin
               state_n = S_GATE;
            end
         end
         S_HOLD: begin
            if (abort_c) begin
               state_n = S_IDLE;
               busy_n  = 1'b0;
               cnt_n   = '0;
            end else if (cnt_q <= CNT_W'(1)) begin
               state_n = S_GATE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         S_GATE: begin
            clr_c   = pend_c & GATE_MASK;
            out_n   = base_c & ~clr_c;
            state_n = S_IDLE;
            busy_n  = 1'b0;
            pwr_n   = 2'b00;
         end
         default: begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            cnt_n   = '0;
            pwr_n   = 2'b00;
         end
      endcase
   end

endmodule

// File: doc/fe_power_seq.md
Name: fe_power_seq

Overview:
Sequences front-end power, reset and I2C-gate controls between the host-written control byte and the board pins. Sits between joker_control's reset_ctrl output and the SW_nEN / FE_*_nRST / TU_IIC0_EN assigns.
- Enables follow power → settle → reset release → hold → I2C gate; disables apply immediately.
- Filters and latches the CI and TPS overcurrent flags and forces the affected supply off.

Parameters:
PWR_SETTLE_CYC, 500000, cycles between power-enable and reset release (10 ms at 50 MHz); 0 = no wait
RST_HOLD_CYC, 50000, cycles between reset release and I2C-gate enable; 0 = no wait
OC_FILTER_CYC, 64, consecutive synchronized-low cycles before an overcurrent latches (≥1)
CNT_W, 24, width of the wait/filter counters; every cycle parameter must be < 2^CNT_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
req_ctrl  in  8  requested control byte, 1 = disabled/in reset (bit7 tuner I2C gate, 6 CI power, 5 antenna 5V, 4 spare, 3:0 demod/tuner resets)
ci_overcurrent_n  in  1  async, active-low
tps_overcurrent_n  in  1  async, active-low
fault_clear  in  1  one-cycle pulse, clears latched faults
out_ctrl  out  8  applied control byte, same encoding as req_ctrl
busy  out  1  enable sequence in progress
oc_fault  out  2  latched overcurrent: [0] CI, [1] TPS

Behaviour:
Reset:
- out_ctrl=8'hFF, busy=0, oc_fault=0, state IDLE, counters 0, synchronizers loaded with 1.
- Reset asserted mid-sequence aborts immediately to these values.

Overcurrent:
- Each *_overcurrent_n passes through a 2-flop synchronizer.
- A filter counter increments while the synchronized input is low and clears when it is high.
- The fault latches when the count reaches OC_FILTER_CYC.
- oc_fault[0] forces out_ctrl[6]=1; oc_fault[1] forces out_ctrl[5]=1, both from the next cycle.
- fault_clear clears only the bits whose synchronized input is currently high.
- Latch and clear in the same cycle: latch wins.

Disables:
- Any req_ctrl bit at 1 drives out_ctrl bit to 1 on the next edge, in every state.
- Bit4 always follows req_ctrl[4] with 1-cycle latency.

Pending enable:
- A bit i in {7,6,5,3,2,1,0} is pending when req_ctrl[i]=0, out_ctrl[i]=1, and it is not blocked by a latched fault.

State machine (registered):
- IDLE: if any bit is pending, go to PWR and set busy=1 on the same edge.
- PWR: clear out_ctrl bits 6:5 that are pending.
  - If any power bit was cleared: load counter with PWR_SETTLE_CYC and go to SETTLE.
  - Otherwise go to REL.
- SETTLE: decrement the counter; go to REL on the cycle it reads 0 (waits exactly PWR_SETTLE_CYC cycles; 0 = no wait).
- REL: clear pending bits 3:0.
  - If any were cleared: load RST_HOLD_CYC and go to HOLD.
  - Otherwise go to GATE.
- HOLD: same countdown as SETTLE, then go to GATE.
- GATE: clear out_ctrl[7] if pending; go to IDLE with busy=0.
  - If new pending bits exist, IDLE restarts the sequence on the following cycle.

Abort:
- In SETTLE or HOLD, if a power bit cleared in this sequence returns to 1 (req or fault), go to IDLE.
- Already-applied bits keep their values; the remaining enables stay pending.

Stage sampling:
- Each stage samples req_ctrl at that stage, so enables requested mid-sequence join any stage not yet passed.
- Bits for stages already passed wait for the next sequence.

Test Plan:
- Reset, then req_ctrl=8'hFF → out_ctrl=8'hFF, busy=0 indefinitely; after reset, req_ctrl=8'h00 with PWR_SETTLE_CYC=10, RST_HOLD_CYC=5 → bits 6:5 clear 2 cycles after req; bits 3:0 clear 11 cycles later; bit7 clears 6 cycles after that; busy falls with the last step.
- Fully enabled (out_ctrl=8'h00); req_ctrl→8'h81 → out_ctrl=8'h81 one cycle later, no sequence, busy=0.
- ci_overcurrent_n low 63 cycles then high → no fault. Low 64+ cycles (OC_FILTER_CYC=64) → oc_fault[0]=1, out_ctrl[6]=1. fault_clear while still low → no effect. Release, then fault_clear → cleared, and a CI re-enable sequence starts.
- During SETTLE, req_ctrl[6]→1 → out_ctrl[6]=1 next cycle, state returns to IDLE, bits 3:0 stay 1, bit 5 keeps its applied value.
- During HOLD, req_ctrl[0] goes 0→1 and req_ctrl[7]→0 → bit0 re-asserts next cycle; bit7 released in GATE.
- Assert reset during HOLD with out_ctrl=8'h90 → out_ctrl=8'hFF, busy=0 next edge; after deassert, a sequence restarts from PWR.
